// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch sequencer (FETCH -> WAIT -> HOLD) with valid/ready output and PC redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a FAULT state and a fetch_misaligned output.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      S_FETCH: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (valid_q && instr_ready) begin
          pc_d    = pc_q + 64'd4;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = state_q;
    endcase

    // Redirect overrides the FSM; a transfer on the same edge still completes.
    if (redirect_valid) begin
      valid_d    = 1'b0;
      cnt_d      = 3'd0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d    = redirect_pc;
      state_d = (redirect_pc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
`else
      pc_d    = redirect_pc & ~64'h3;
      state_d = S_FETCH;
`endif
    end

    mem_addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      cnt_q      <= 3'd0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 64'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Strobe is gated by reset so it stays low while reset is held.
  assign mem_rd      = (state_q == S_FETCH) && !reset;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = (state_q == S_FAULT);
`endif

endmodule
